dec_entry: RTL and testbench
============================

# dec_entry

Sequential decimal-entry front end for the ALU datapath: accepts keypad-style key events (digits, sign, clear, enter), holds the entered signed decimal number and presents it as BCD nibbles for the existing bcd2seg display path. On enter, it converts the signed decimal value to a `width`-bit two's-complement operand over several cycles and flags values outside the representable range. It is the input-side inverse of the bin2bcd/bcd2seg display chain and feeds the `a`/`b` operand registers.

## Interface
- `width`, 6, bit width of the binary result (two's complement).
- `digits`, 2, maximum number of decimal digits held; internal accumulator sized to ceil(log2(10^digits)) bits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `key_valid`  in  1  key event present this cycle.
- `key_code`  in  4  0-9 digit; 4'hA sign toggle; 4'hC clear; 4'hE enter; 4'hB, 4'hD, 4'hF ignored.
- `key_ready`  out  1  block accepts a key this cycle.
- `bcd`  out  4*digits  entered digits, most significant nibble first; blank nibble = 4'hF.
- `bcd_sgn`  out  4  4'hA when negative sign set, else 4'hF.
- `bin`  out  width  last converted value.
- `bin_valid`  out  1  one-cycle pulse: `bin`/`err` updated.
- `err`  out  1  last conversion out of range.

## Operation
- Key accepted on a rising edge where `key_valid && key_ready`; no effect otherwise.
- States: ENTRY, CONV, DONE. Reset -> ENTRY.
- ENTRY (`key_ready`=1):
  - Digit: if count < `digits`, shift digit buffer left one nibble, insert digit in least-significant nibble, count+1; if count == `digits`, key ignored.
  - 4'hA: toggle sign flag.
  - 4'hC: count=0, sign=0, digit buffer all zero; `bin`, `err` unchanged.
  - 4'hE: latch buffer and sign, clear accumulator, digit index=0, go CONV.
- CONV (`key_ready`=0): one digit per cycle, most significant first: acc = (acc<<3) + (acc<<1) + digit. After `digits` cycles go DONE.
- DONE (`key_ready`=0): range check and sign apply in one cycle:
  - positive: err = acc > 2^(width-1)-1; negative: err = acc > 2^(width-1).
  - err=0: `bin` = sign ? -acc : acc (truncated to `width`); err=1: `bin` = 0.
  - -0 yields `bin`=0, err=0.
  - Register `bin`, `err`, assert `bin_valid`; clear count, sign, buffer; go ENTRY.
- Display: positions at index >= count (counting from least-significant) show 4'hF, except count=0 shows 4'h0 in least-significant nibble. `bcd_sgn` follows sign flag in ENTRY; during CONV/DONE shows latched value.
- `err` holds until next DONE; cleared by reset only otherwise.

## Timing
- Reset values: `key_ready`=1, `bin`=0, `bin_valid`=0, `err`=0, `bcd` = all 4'hF except LS nibble 4'h0, `bcd_sgn`=4'hF.
- Enter accepted at edge k: `key_ready` low after edge k; CONV at edges k+1..k+`digits`; DONE at edge k+`digits`+1 registers outputs.
- `bin_valid` high exactly one cycle, starting `digits`+1 cycles after accept; `key_ready` returns high in that same cycle.
- Keys presented while `key_ready`=0 are dropped, not queued.
- `rst` in any state, including mid-CONV, returns to reset values at that edge; no `bin_valid` for the aborted conversion.
- All outputs registered; no combinational path from `key_*` to outputs.

## Test plan
- Keys 3,1,E (defaults) -> `bin`=6'b011111 (31), `err`=0, `bin_valid` pulse 3 cycles after E accepted, `key_ready` low for those 3 cycles.
- Keys A,3,2,E -> `bin`=6'b100000 (-32), `err`=0; `bcd_sgn`=4'hA before E.
- Keys 3,2,E -> `err`=1, `bin`=0; then A,9,E -> `err`=0, `bin`=6'b110111 (-9).
- Keys 4,5,6 -> `bcd`=8'h45 (third digit ignored); C -> `bcd`=8'hF0, `bcd_sgn`=4'hF; A,A -> sign clear.
- Keys 7,E then digit 5 with `key_valid` held during CONV -> 5 dropped, `bin`=7; after return, `bcd`=8'hF0.
- Keys 2,E, `rst` asserted one cycle after accept -> no `bin_valid`, all outputs at reset values, `key_ready`=1 next cycle.

Source files
------------

// File: rtl/dec_entry.sv
// Keypad decimal entry: collects signed decimal digits for display, then converts
// them on enter to a width-bit two's-complement operand with a range flag.
module dec_entry #(
    parameter int width  = 6,
    parameter int digits = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  key_ready,
    output logic [4*digits-1:0]   bcd,
    output logic [3:0]            bcd_sgn,
    output logic [width-1:0]      bin,
    output logic                  bin_valid,
    output logic                  err
);

    localparam int ACC_W = $clog2(10**digits);
    localparam int CNT_W = $clog2(digits + 1);
    localparam int IDX_W = (digits > 1) ? $clog2(digits) : 1;
    localparam int CMP_W = ((ACC_W > width) ? ACC_W : width) + 1;
    localparam logic [CMP_W-1:0] POS_MAX = CMP_W'((2**(width-1)) - 1);
    localparam logic [CMP_W-1:0] NEG_MAX = CMP_W'(2**(width-1));

    typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     count, count_next;
    logic                 sign, sign_next;
    logic [4*digits-1:0]  digit_buf, digit_buf_next;
    logic [4*digits-1:0]  lat_buf, lat_buf_next;
    logic                 lat_sign, lat_sign_next;
    logic [ACC_W-1:0]     acc, acc_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [width-1:0]     bin_next;
    logic                 err_next;

    logic [CMP_W-1:0]     acc_ext;
    logic [width-1:0]     acc_w;
    logic                 range_err;
    logic [width-1:0]     signed_val;

    // Unentered positions are blanked; an empty entry still shows a single zero.
    function automatic logic [4*digits-1:0] display(input logic [CNT_W-1:0] cnt,
                                                    input logic [4*digits-1:0] dbuf);
        logic [4*digits-1:0] d;
        d = '1;
        for (int i = 0; i < digits; i++) begin
            if (i < int'(cnt)) d[4*i +: 4] = dbuf[4*i +: 4];
        end
        if (cnt == '0) d[3:0] = 4'h0;
        return d;
    endfunction

    assign acc_ext    = CMP_W'(acc);
    assign acc_w      = width'(acc);
    assign range_err  = lat_sign ? (acc_ext > NEG_MAX) : (acc_ext > POS_MAX);
    assign signed_val = lat_sign ? ({width{1'b0}} - acc_w) : acc_w;

    always_ff @(posedge clk) begin
        if (rst) state <= ENTRY;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        count_next     = count;
        sign_next      = sign;
        digit_buf_next = digit_buf;
        lat_buf_next   = lat_buf;
        lat_sign_next  = lat_sign;
        acc_next       = acc;
        idx_next       = idx;
        bin_next       = bin;
        err_next       = err;
        case (state)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (count < CNT_W'(digits)) begin
                            digit_buf_next      = digit_buf << 4;
                            digit_buf_next[3:0] = key_code;
                            count_next          = count + 1'b1;
                        end
                    end else begin
                        case (key_code)
                            4'hA: sign_next = ~sign;
                            4'hC: begin
                                count_next     = '0;
                                sign_next      = 1'b0;
                                digit_buf_next = '0;
                            end
                            4'hE: begin
                                lat_buf_next  = digit_buf;
                                lat_sign_next = sign;
                                acc_next      = '0;
                                idx_next      = '0;
                                state_next    = CONV;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CONV: begin
                // Multiply by ten as shift-and-add, consuming the top nibble each cycle.
                acc_next     = (acc << 3) + (acc << 1) + ACC_W'(lat_buf[4*digits-1 -: 4]);
                lat_buf_next = lat_buf << 4;
                idx_next     = idx + 1'b1;
                if (idx == IDX_W'(digits - 1)) state_next = DONE;
            end
            DONE: begin
                err_next       = range_err;
                bin_next       = range_err ? '0 : signed_val;
                count_next     = '0;
                sign_next      = 1'b0;
                digit_buf_next = '0;
                state_next     = ENTRY;
            end
            default: state_next = ENTRY;
        endcase
    end

    // Outputs are registered from the next-state values so they track state without lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            sign      <= 1'b0;
            digit_buf <= '0;
            lat_buf   <= '0;
            lat_sign  <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            bin       <= '0;
            err       <= 1'b0;
            bin_valid <= 1'b0;
            key_ready <= 1'b1;
            bcd       <= display('0, '0);
            bcd_sgn   <= 4'hF;
        end else begin
            count     <= count_next;
            sign      <= sign_next;
            digit_buf <= digit_buf_next;
            lat_buf   <= lat_buf_next;
            lat_sign  <= lat_sign_next;
            acc       <= acc_next;
            idx       <= idx_next;
            bin       <= bin_next;
            err       <= err_next;
            bin_valid <= (state == DONE);
            key_ready <= (state_next == ENTRY);
            bcd       <= display(count_next, digit_buf_next);
            if (state_next == ENTRY) bcd_sgn <= sign_next ? 4'hA : 4'hF;
            else                     bcd_sgn <= lat_sign_next ? 4'hA : 4'hF;
        end
    end

endmodule

// File: tb/tb_dec_entry.sv
// Scoreboard bench for dec_entry: a digit-list reference model predicts display
// and conversion results; a monitor checks every bin_valid pulse against the queue.
module tb_dec_entry;

    localparam int WIDTH  = 6;
    localparam int DIGITS = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 key_valid;
    logic [3:0]           key_code;
    logic                 key_ready;
    logic [4*DIGITS-1:0]  bcd;
    logic [3:0]           bcd_sgn;
    logic [WIDTH-1:0]     bin;
    logic                 bin_valid;
    logic                 err;

    typedef struct {
        logic [WIDTH-1:0] bin;
        logic             err;
    } result_t;

    result_t sb[$];
    int      model_q[$];
    bit      model_sign;
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    dec_entry #(.width(WIDTH), .digits(DIGITS)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .bcd(bcd), .bcd_sgn(bcd_sgn), .bin(bin),
        .bin_valid(bin_valid), .err(err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Display expectation: entered digits right-aligned, blanks to the left.
    function automatic logic [4*DIGITS-1:0] expBcd();
        logic [4*DIGITS-1:0] r;
        r = '1;
        for (int i = 0; i < model_q.size(); i++)
            r[4*(model_q.size()-1-i) +: 4] = 4'(model_q[i]);
        if (model_q.size() == 0) r[3:0] = 4'h0;
        return r;
    endfunction

    function automatic result_t expResult();
        result_t r;
        int v;
        v = 0;
        foreach (model_q[i]) v = v * 10 + model_q[i];
        r.err = model_sign ? (v > 2**(WIDTH-1)) : (v > 2**(WIDTH-1) - 1);
        r.bin = r.err ? '0 : WIDTH'(model_sign ? -v : v);
        return r;
    endfunction

    task automatic modelKey(input logic [3:0] code);
        if (code <= 4'd9) begin
            if (model_q.size() < DIGITS) model_q.push_back(int'(code));
        end else if (code == 4'hA) begin
            model_sign = ~model_sign;
        end else if (code == 4'hC) begin
            model_q.delete();
            model_sign = 1'b0;
        end else if (code == 4'hE) begin
            sb.push_back(expResult());
            model_q.delete();
            model_sign = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        modelKey(code);
        @(negedge clk);
        key_valid = 1'b0;
        if (code != 4'hE) begin
            checkOutput("bcd", 32'(bcd), 32'(expBcd()));
            checkOutput("bcd_sgn", 32'(bcd_sgn), model_sign ? 32'hA : 32'hF);
            checkOutput("key_ready_entry", 32'(key_ready), 32'd1);
        end
    endtask

    // Called at the first negedge after enter is accepted; optionally holds a key during the busy window.
    task automatic waitResult(input bit hold, input logic [3:0] hcode);
        int j;
        j = 0;
        if (hold) begin
            key_valid = 1'b1;
            key_code  = hcode;
        end
        while (!bin_valid && j < 20) begin
            checkOutput("key_ready_busy", 32'(key_ready), 32'd0);
            @(negedge clk);
            j++;
        end
        key_valid = 1'b0;
        checkOutput("latency", 32'(j), 32'(DIGITS + 1));
        checkOutput("key_ready_back", 32'(key_ready), 32'd1);
        @(negedge clk);
        checkOutput("bin_valid_pulse", 32'(bin_valid), 32'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_key_ready", 32'(key_ready), 32'd1);
        checkOutput("rst_bin", 32'(bin), 32'd0);
        checkOutput("rst_bin_valid", 32'(bin_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_bcd", 32'(bcd), 32'(expBcd()));
        checkOutput("rst_bcd_sgn", 32'(bcd_sgn), 32'hF);
    endtask

    always @(negedge clk) begin
        if (bin_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_bin_valid: got bin=0x%0h err=%0b, expected no result", bin, err);
            end else begin
                result_t r;
                r = sb.pop_front();
                checkOutput("bin", 32'(bin), 32'(r.bin));
                checkOutput("err", 32'(err), 32'(r.err));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        model_sign = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkResetValues();

        $display("[TB] positive maximum 31");
        applyStimulus(4'h3); applyStimulus(4'h1); applyStimulus(4'hE);
        waitResult(1'b0, 4'h0);

        $display("[TB] negative minimum -32");
        applyStimulus(4'hA); applyStimulus(4'h3); applyStimulus(4'h2); applyStimulus(4'hE);
        waitResult(1'b0, 4'h0);

        $display("[TB] out of range then -9");
        applyStimulus(4'h3); applyStimulus(4'h2); applyStimulus(4'hE);
        waitResult(1'b0, 4'h0);
        applyStimulus(4'hA); applyStimulus(4'h9); applyStimulus(4'hE);
        waitResult(1'b0, 4'h0);

        $display("[TB] digit overflow, clear, sign toggle");
        applyStimulus(4'h4); applyStimulus(4'h5); applyStimulus(4'h6);
        applyStimulus(4'hC); applyStimulus(4'hA); applyStimulus(4'hA);

        $display("[TB] keys dropped while busy");
        applyStimulus(4'h7); applyStimulus(4'hE);
        waitResult(1'b1, 4'h5);
        checkOutput("bcd_after_drop", 32'(bcd), 32'h0000_00F0);

        $display("[TB] reset during conversion");
        applyStimulus(4'h2); applyStimulus(4'hE);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        checkResetValues();
        repeat (6) begin
            @(negedge clk);
            checkOutput("no_bin_valid_after_abort", 32'(bin_valid), 32'd0);
        end

        $display("[TB] randomized entries");
        for (int s = 0; s < 40; s++) begin
            int nkeys;
            nkeys = $urandom_range(0, 5);
            for (int k = 0; k < nkeys; k++) begin
                logic [3:0] c;
                c = 4'($urandom_range(0, 15));
                if (c == 4'hE) c = 4'hB;
                applyStimulus(c);
            end
            applyStimulus(4'hE);
            waitResult(1'b0, 4'h0);
        end

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
